// File: rtl/approx_acc_pkg.sv
// Shared types and widths for the approximate dot-product accumulator.
package approx_acc_pkg;
    typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_e;

    localparam int PROD_W = 16;
    localparam int CNT_W  = 8;
endpackage

// File: rtl/acc_add_sat.sv
// Combinational ACC_W-bit adder of accumulator plus zero-extended product.
// Define ACC_SAT_EN to clamp the sum to all-ones on carry instead of wrapping.
module acc_add_sat
    import approx_acc_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] prod_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              carry_o
);
    logic [ACC_W:0] full_sum;

    assign full_sum = {1'b0, acc_i} + {{(ACC_W - PROD_W + 1){1'b0}}, prod_i};
    assign carry_o  = full_sum[ACC_W];

`ifdef ACC_SAT_EN
    // Once clamped, any further non-zero product carries again, so the value sticks.
    assign sum_o = carry_o ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
    assign sum_o = full_sum[ACC_W-1:0];
`endif
endmodule

// File: rtl/approx_dot_acc.sv
// Sums LEN 16-bit approximate products per vector and presents the sum plus
// a sticky overflow flag on a valid/ready port. ACC_SAT_EN selects saturation.
module approx_dot_acc
    import approx_acc_pkg::*;
#(
    parameter int LEN   = 16,
    parameter int ACC_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf
);
    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sticky_q, sticky_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_acc_q, out_acc_d;
    logic               out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0]   sum;
    logic               carry;
    logic               accept;
    logic               last_elem;

    acc_add_sat #(.ACC_W(ACC_W)) u_add (
        .acc_i   (acc_q),
        .prod_i  (in_prod),
        .sum_o   (sum),
        .carry_o (carry)
    );

    // Pure state decode keeps the input side free of combinational paths.
    assign in_ready  = (state_q == ACC);
    assign accept    = in_valid & in_ready;
    assign last_elem = (cnt_q == CNT_W'(LEN - 1));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sticky_d    = sticky_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            ACC: begin
                if (accept) begin
                    if (last_elem) begin
                        out_acc_d   = sum;
                        out_ovf_d   = sticky_q | carry;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        sticky_d    = 1'b0;
                        state_d     = HOLD;
                    end else begin
                        acc_d    = sum;
                        cnt_d    = cnt_q + 1'b1;
                        sticky_d = sticky_q | carry;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_approx_dot_acc.sv
// Bench for approx_dot_acc: instance A (LEN=4, ACC_W=24) and B (LEN=3, ACC_W=17)
// driven by directed and random vectors, checked against a plain-arithmetic model.
module tb_approx_dot_acc;
    logic        clk;
    logic        rst;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
    logic [15:0] a_in_prod;
    logic [23:0] a_out_acc;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
    logic [15:0] b_in_prod;
    logic [16:0] b_out_acc;

    int checks = 0;
    int errors = 0;
    logic [15:0] vq[$];

    approx_dot_acc #(.LEN(4), .ACC_W(24)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_prod(a_in_prod),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_acc(a_out_acc), .out_ovf(a_out_ovf)
    );

    approx_dot_acc #(.LEN(3), .ACC_W(17)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_prod(b_in_prod),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_acc(b_out_acc), .out_ovf(b_out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit b, input logic v, input logic [15:0] p);
        if (b) begin b_in_valid = v; b_in_prod = p; end
        else begin a_in_valid = v; a_in_prod = p; end
    endtask

    task automatic set_oready(input bit b, input logic v);
        if (b) b_out_ready = v; else a_out_ready = v;
    endtask

    function automatic logic cur_ready(input bit b);
        return b ? b_in_ready : a_in_ready;
    endfunction
    function automatic logic cur_valid(input bit b);
        return b ? b_out_valid : a_out_valid;
    endfunction
    function automatic logic [31:0] cur_acc(input bit b);
        return b ? {15'd0, b_out_acc} : {8'd0, a_out_acc};
    endfunction
    function automatic logic cur_ovf(input bit b);
        return b ? b_out_ovf : a_out_ovf;
    endfunction

    // Reference: running integer sum; any partial sum reaching 2^w flags overflow.
    function automatic logic [32:0] model(input logic [15:0] q[$], input int w);
        longint s = 0;
        longint m = longint'(1) << w;
        bit     ovf = 1'b0;
        foreach (q[i]) begin
            s += longint'(q[i]);
            if (s >= m) begin
                ovf = 1'b1;
`ifdef ACC_SAT_EN
                s = m - 1;
`else
                s -= m;
`endif
            end
        end
        return {ovf, 32'(s)};
    endfunction

    // Streams one vector, optionally with idle bubbles, then holds the result for `stall` cycles.
    task automatic vec(input bit b, input logic [15:0] q[$], input bit bubbles,
                       input int stall, input string tag);
        logic [32:0] exp;
        int          w;
        int          guard;
        w   = b ? 17 : 24;
        exp = model(q, w);
        for (int i = 0; i < q.size(); i++) begin
            if (bubbles) begin
                repeat ($urandom_range(0, 2)) begin
                    drive(b, 1'b0, 16'($urandom));
                    tick();
                end
            end
            drive(b, 1'b1, q[i]);
            guard = 0;
            while (!cur_ready(b) && guard < 20) begin
                tick();
                guard++;
            end
            chk({tag, "_in_ready"}, 32'(cur_ready(b)), 32'd1);
            if (i == q.size() - 1 && stall > 0) begin
                tick();
                set_oready(b, 1'b0);
            end else begin
                tick();
            end
            if (i < q.size() - 1) chk({tag, "_early_valid"}, 32'(cur_valid(b)), 32'd0);
        end
        drive(b, 1'b0, 16'd0);
        chk({tag, "_out_valid"}, 32'(cur_valid(b)), 32'd1);
        chk({tag, "_out_acc"}, cur_acc(b), exp[31:0]);
        chk({tag, "_out_ovf"}, 32'(cur_ovf(b)), 32'(exp[32]));
        for (int s = 0; s < stall; s++) begin
            drive(b, 1'($urandom), 16'($urandom));
            tick();
            chk({tag, "_hold_valid"}, 32'(cur_valid(b)), 32'd1);
            chk({tag, "_hold_acc"}, cur_acc(b), exp[31:0]);
            chk({tag, "_hold_ready"}, 32'(cur_ready(b)), 32'd0);
        end
        drive(b, 1'b0, 16'd0);
        set_oready(b, 1'b1);
        tick();
        chk({tag, "_released"}, 32'(cur_valid(b)), 32'd0);
        chk({tag, "_ready_again"}, 32'(cur_ready(b)), 32'd1);
        $display("vector %s: sum=%0d ovf=%0d stall=%0d", tag, exp[31:0], exp[32], stall);
    endtask

    initial begin
        logic [15:0] bprods[4];
        bit          pat[7];
        int          k;

        rst = 1'b1;
        a_in_valid = 0; a_in_prod = 0; a_out_ready = 1;
        b_in_valid = 0; b_in_prod = 0; b_out_ready = 1;
        repeat (3) tick();
        chk("rst_a_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_a_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_a_out_acc", {8'd0, a_out_acc}, 32'd0);
        chk("rst_a_out_ovf", 32'(a_out_ovf), 32'd0);
        chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
        rst = 1'b0;
        tick();

        // Partial vector discarded by an asynchronous reset pulse.
        drive(0, 1'b1, 16'd100); tick();
        drive(0, 1'b1, 16'd200); tick();
        drive(0, 1'b0, 16'd0);
        rst = 1'b1;
        #2;
        chk("rstmid_in_ready", 32'(a_in_ready), 32'd1);
        tick();
        rst = 1'b0;
        vq.delete(); vq.push_back(1); vq.push_back(2); vq.push_back(3); vq.push_back(4);
        vec(0, vq, 0, 0, "rstmid");
        chk("rstmid_sum10", {8'd0, a_out_acc}, 32'd10);

        vq.delete(); vq.push_back(225); vq.push_back(65025); vq.push_back(0); vq.push_back(16);
        vec(0, vq, 0, 0, "basic");
        chk("basic_sum", {8'd0, a_out_acc}, 32'd65266);
        vec(0, vq, 0, 5, "backpressure");

        // Directed bubble pattern; garbage on in_prod while in_valid is low.
        bprods = '{16'd10, 16'd20, 16'd30, 16'd40};
        pat    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        k = 0;
        for (int i = 0; i < 7; i++) begin
            if (pat[i]) begin drive(0, 1'b1, bprods[k]); k++; end
            else drive(0, 1'b0, 16'($urandom));
            tick();
        end
        drive(0, 1'b0, 16'd0);
        chk("bubble_valid", 32'(a_out_valid), 32'd1);
        chk("bubble_acc", {8'd0, a_out_acc}, 32'd100);
        chk("bubble_ovf", 32'(a_out_ovf), 32'd0);
        tick();
        chk("bubble_release", 32'(a_out_valid), 32'd0);

        vq.delete(); repeat (3) vq.push_back(16'd65535);
        vec(1, vq, 0, 0, "ovf3");
`ifdef ACC_SAT_EN
        chk("sat_value", {15'd0, b_out_acc}, 32'd131071);
`else
        chk("wrap_value", {15'd0, b_out_acc}, 32'd65533);
`endif
        vq.delete(); repeat (3) vq.push_back(16'd1);
        vec(1, vq, 0, 0, "after_ovf");
        chk("after_ovf_flag", 32'(b_out_ovf), 32'd0);

        for (int r = 0; r < 6; r++) begin
            vq.delete();
            repeat (4) vq.push_back(16'($urandom));
            vec(0, vq, 1, $urandom_range(0, 3), $sformatf("randA%0d", r));
        end
        for (int r = 0; r < 8; r++) begin
            vq.delete();
            repeat (3) vq.push_back(16'($urandom_range(20000, 65535)));
            vec(1, vq, 1, $urandom_range(0, 3), $sformatf("randB%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
